sr_latch_sequencer: RTL and testbench
=====================================

Name: sr_latch_sequencer

Overview:
- Clocked controller that drives the set/reset inputs of an asynchronous cross-coupled NOR SR latch.
- Turns single-cycle set/clear requests into S and R pulses of fixed width, guaranteed never to overlap, followed by a dead time.
- Reads the latch outputs back through a synchronizer and checks that the latch reached the commanded state.
- Sits between user logic (buttons, FSMs) and a structural latch on the MAX1000 board.

Parameters:
PULSE_W  4  cycles S or R is held high per command; legal range 1..15
DEAD_W   3  cycles both S and R are held low after a pulse, before checking; legal range 2..15 (must cover the 2-flop synchronizer)

Ports:
clk        input   1  system clock
rst_n      input   1  asynchronous active-low reset
set_req    input   1  one-cycle request to set the latch (q=1)
clr_req    input   1  one-cycle request to clear the latch (q=0)
fault_clr  input   1  clears the sticky fault flag
latch_q    input   1  latch q output (asynchronous; synchronized internally)
latch_qn   input   1  latch complementary output (asynchronous; synchronized internally)
s_out      output  1  registered drive to latch S
r_out      output  1  registered drive to latch R
busy       output  1  high while any state other than IDLE is active
done       output  1  one-cycle pulse on completion or skip
fault      output  1  sticky; latch state mismatch or illegal q==qn
target     output  1  last commanded latch value

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_out=r_out=busy=done=fault=target=0; pending slot empty; synchronizer flops=0.
- Both input pairs pass through 2-flop synchronizers; q_s and qn_s are the synchronized values.
- Request decode: if set_req and clr_req are high in the same cycle, clear wins. Requests are edge-free; each high cycle counts as one request.
- States: IDLE, PULSE, DEAD, CHECK.
- IDLE, on a request (or a pending request, which is serviced first):
  - If the request value equals target and q_s matches target and qn_s differs from q_s, it is skipped: done=1 for one cycle, state stays IDLE, no pulse is driven.
  - Otherwise: target <= requested value; state -> PULSE; counter <= PULSE_W-1.
- PULSE:
  - s_out=target and r_out=~target, registered, so they assert the cycle after the request edge.
  - s_out and r_out are never both 1 in any cycle.
  - When the counter reaches 0: state -> DEAD; counter <= DEAD_W-1.
- DEAD: s_out=r_out=0. When the counter reaches 0: state -> CHECK.
- CHECK, single cycle:
  - done=1.
  - If q_s != target or q_s == qn_s, fault <= 1 at the next edge.
  - state -> IDLE.
- Busy window: busy=1 in PULSE, DEAD and CHECK. The command takes PULSE_W + DEAD_W + 1 cycles from the first pulse cycle to the return to IDLE.
- Pending slot (one entry):
  - A request arriving while busy is stored in the slot.
  - A later request overwrites the stored one.
  - A clear arriving together with a set overwrites it as a clear.
  - The slot is serviced on the first IDLE cycle after CHECK and is emptied when accepted.
  - A new request in that same IDLE cycle has priority over the slot, and the slot is discarded.
- Fault: stays set until fault_clr=1, or until reset. If fault_clr and a new fault detection occur in the same cycle, the detection wins (fault stays 1). Sequencing continues normally while the fault is set.
- Reset mid-command: S and R drop to 0 immediately (asynchronous); the latch keeps its own state. After reset, target=0 regardless of the actual q.
- Counter width: 4 bits. Parameters outside their legal range are unsupported.

Test Plan:
- Reset, then set_req pulse at cycle 10, with a latch model responding in 1 ns -> s_out=1 for cycles 11-14, r_out=0 throughout, CHECK/done at cycle 18, fault=0, target=1, busy=1 for cycles 11-18.
- With q=1 and target=1, pulse set_req -> done=1 the next cycle, s_out and r_out stay 0, busy stays 0.
- set_req and clr_req together from the cleared state with q=1 -> r_out pulse of 4 cycles, s_out=0, target=0.
- While busy from a set: clr_req at busy cycle 2, then set_req at busy cycle 4 -> after CHECK exactly one more command (a set) runs and is skipped because the latch already matches; the clear is lost.
- Latch model stuck at q=0 and qn=0, then set_req -> fault=1 the cycle after CHECK and stays set across a second command; fault_clr=1 for one cycle -> fault=0.
- rst_n asserted during cycle 2 of PULSE -> s_out=0 within the same cycle, state IDLE, pending slot empty; a set_req after release runs a full 8-cycle sequence.
- Every test: assertion that s_out && r_out never holds.

Source files
------------

// File: rtl/sr_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_sequencer
// Brief    : Drives the S/R inputs of an external cross-coupled NOR latch with
//            fixed-width, non-overlapping pulses followed by a dead time, then
//            checks the synchronized latch outputs against the commanded value.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_sequencer #(
  parameter int PULSE_W = 4,
  parameter int DEAD_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic fault_clr,
  input  logic latch_q,
  input  logic latch_qn,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic done,
  output logic fault,
  output logic target
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_pulse = 2'd1;
  localparam logic [1:0] c_st_dead  = 2'd2;
  localparam logic [1:0] c_st_check = 2'd3;

  localparam logic [3:0] c_pulse_last = 4'(PULSE_W - 1);
  localparam logic [3:0] c_dead_last  = 4'(DEAD_W - 1);

  logic       r_q_meta, r_q_s, r_qn_meta, r_qn_s;
  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_target;
  logic       r_slot_vld, r_slot_val;
  logic       r_s_out, r_r_out, r_done, r_fault;

  logic       w_req, w_req_val;
  logic       w_cmd_vld, w_cmd_val;
  logic       w_skip;
  logic [1:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_target_nxt;
  logic       w_busy, w_s_nxt, w_r_nxt, w_done_nxt;
  logic       w_mismatch;

  // A simultaneous set and clear decodes as a clear.
  assign w_req      = set_req | clr_req;
  assign w_req_val  = set_req & ~clr_req;
  // A fresh request outranks the pending slot.
  assign w_cmd_vld  = w_req | r_slot_vld;
  assign w_cmd_val  = w_req ? w_req_val : r_slot_val;
  // Latch did not land on the target, or both rails read equal (illegal).
  assign w_mismatch = (r_q_s != r_target) | (r_q_s == r_qn_s);

  // Two-flop synchronizers for the asynchronous latch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta  <= 1'b0;
      r_q_s     <= 1'b0;
      r_qn_meta <= 1'b0;
      r_qn_s    <= 1'b0;
    end else begin
      r_q_meta  <= latch_q;
      r_q_s     <= r_q_meta;
      r_qn_meta <= latch_qn;
      r_qn_s    <= r_qn_meta;
    end
  end

  // State register with its phase counter and commanded target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_cnt    <= 4'd0;
      r_target <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Next-state logic: accept or skip commands, time the pulse and dead phases.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_skip       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_cmd_vld) begin
          if ((w_cmd_val == r_target) && (r_q_s == r_target) && (r_qn_s != r_q_s)) begin
            w_skip = 1'b1;
          end else begin
            w_target_nxt = w_cmd_val;
            w_state_nxt  = c_st_pulse;
            w_cnt_nxt    = c_pulse_last;
          end
        end
      end
      c_st_pulse: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_st_dead;
          w_cnt_nxt   = c_dead_last;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      c_st_dead: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_st_check;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output decode: S and R come from one target bit, so they cannot overlap.
  always_comb begin
    w_busy     = (r_state != c_st_idle);
    w_s_nxt    = (w_state_nxt == c_st_pulse) &  w_target_nxt;
    w_r_nxt    = (w_state_nxt == c_st_pulse) & ~w_target_nxt;
    w_done_nxt = w_skip | (w_state_nxt == c_st_check);
  end

  // Registered latch drives and completion strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_out <= 1'b0;
      r_r_out <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_s_out <= w_s_nxt;
      r_r_out <= w_r_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // One-entry pending slot: filled while busy, emptied on any idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld <= 1'b0;
      r_slot_val <= 1'b0;
    end else if (r_state == c_st_idle) begin
      r_slot_vld <= 1'b0;
    end else if (w_req) begin
      r_slot_vld <= 1'b1;
      r_slot_val <= w_req_val;
    end
  end

  // Sticky fault; a detection in the same cycle as fault_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if ((r_state == c_st_check) && w_mismatch) begin
      r_fault <= 1'b1;
    end else if (fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  assign s_out  = r_s_out;
  assign r_out  = r_r_out;
  assign busy   = w_busy;
  assign done   = r_done;
  assign fault  = r_fault;
  assign target = r_target;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_sequencer
// Brief    : Directed self-checking bench for sr_latch_sequencer with a
//            behavioural NOR latch model (1 ns response, optional stuck-at-00).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic fault_clr = 1'b0;
  logic latch_q = 1'b0;
  logic latch_qn = 1'b1;
  logic s_out, r_out, busy, done, fault, target;

  logic stuck = 1'b0;
  logic preset_q = 1'b0;
  logic preset_tgl = 1'b0;
  logic last_tgl = 1'b0;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  sr_latch_sequencer #(.PULSE_W(4), .DEAD_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .fault_clr (fault_clr),
    .latch_q   (latch_q),
    .latch_qn  (latch_qn),
    .s_out     (s_out),
    .r_out     (r_out),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .target    (target)
  );

  // NOR latch model: responds 1 ns after S/R change, holds otherwise.
  always @(s_out or r_out or stuck or preset_tgl) begin
    #1;
    if (stuck) begin
      latch_q = 1'b0; latch_qn = 1'b0;
    end else if (s_out && !r_out) begin
      latch_q = 1'b1; latch_qn = 1'b0;
    end else if (r_out && !s_out) begin
      latch_q = 1'b0; latch_qn = 1'b1;
    end else if (preset_tgl != last_tgl) begin
      latch_q = preset_q; latch_qn = ~preset_q;
    end
    last_tgl = preset_tgl;
  end

  // S and R must never be high together.
  always @(s_out or r_out) begin
    if (s_out && r_out) overlap_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0;
    repeat (3) tick();
    got = {s_out, r_out, busy, done, fault, target};
    checks++;
    if (got !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=000000", got);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    got = {s_out, r_out, busy, done, fault, target};
    checks++;
    if (got !== 6'b0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=000000", got);
    end
  endtask

  task automatic test_set_sequence();
    logic [4:0] got, exp;
    set_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      set_req = 1'b0;
      got = {s_out, r_out, busy, done, target};
      exp = {k <= 4, 1'b0, k <= 8, k == 8, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL set_seq k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    checks++;
    if ({fault, latch_q} !== 2'b01) begin
      errors++;
      $display("FAIL set_seq_end fault/q got=%b exp=01", {fault, latch_q});
    end
  endtask

  task automatic test_skip();
    logic [4:0] got, exp;
    repeat (2) tick();
    set_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      set_req = 1'b0;
      got = {s_out, r_out, busy, done, target};
      exp = {1'b0, 1'b0, 1'b0, k == 1, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL skip k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_both_clear();
    logic [4:0] got, exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({target, latch_q} !== 2'b01) begin
      errors++;
      $display("FAIL both_pre target/q got=%b exp=01", {target, latch_q});
    end
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      set_req = 1'b0;
      clr_req = 1'b0;
      got = {s_out, r_out, busy, done, target};
      exp = {1'b0, k <= 4, k <= 8, k == 8, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL both_clear k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    checks++;
    if ({fault, latch_q} !== 2'b00) begin
      errors++;
      $display("FAIL both_end fault/q got=%b exp=00", {fault, latch_q});
    end
  endtask

  task automatic test_pending();
    logic [4:0] got, exp;
    set_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {s_out, r_out, busy, done, target};
      exp = {k <= 4, 1'b0, k <= 8, (k == 8) || (k == 10), 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pending k=%0d got=%b exp=%b", k, got, exp);
      end
      clr_req = (k == 2);
      set_req = (k == 4);
    end
  endtask

  task automatic test_fault();
    logic [5:0] got, exp;
    stuck = 1'b1;
    repeat (3) tick();
    set_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      set_req = 1'b0;
      got = {s_out, r_out, busy, done, target, fault};
      exp = {k <= 4, 1'b0, k <= 8, k == 8, 1'b1, k == 9};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fault_first k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    clr_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      clr_req = 1'b0;
      got = {s_out, r_out, busy, done, target, fault};
      exp = {1'b0, k <= 4, k <= 8, k == 8, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fault_sticky k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got=%b exp=0", fault);
    end
    set_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      set_req = 1'b0;
      got = {s_out, r_out, busy, done, target, fault};
      exp = {k <= 4, 1'b0, k <= 8, k == 8, 1'b1, k == 9};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fault_vs_clr k=%0d got=%b exp=%b", k, got, exp);
      end
      fault_clr = (k == 8);
    end
    stuck = 1'b0;
    preset_q = 1'b1;
    preset_tgl = ~preset_tgl;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
    checks++;
    if ({fault, latch_q, latch_qn} !== 3'b010) begin
      errors++;
      $display("FAIL fault_recover fault/q/qn got=%b exp=010", {fault, latch_q, latch_qn});
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got, exp;
    clr_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      clr_req = 1'b0;
      got = {s_out, r_out, busy, done, target};
      exp = {1'b0, k <= 4, k <= 8, k == 8, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_pre k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checks++;
    if ({s_out, busy, latch_q} !== 3'b111) begin
      errors++;
      $display("FAIL mid_pulse s/busy/q got=%b exp=111", {s_out, busy, latch_q});
    end
    rst_n = 1'b0;
    #1;
    got = {s_out, r_out, busy, done, target};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL mid_async got=%b exp=00000", got);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      got = {s_out, r_out, busy, done, target};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL mid_slot_empty k=%0d got=%b exp=00000", k, got);
      end
    end
    set_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      set_req = 1'b0;
      got = {s_out, r_out, busy, done, target};
      exp = {k <= 4, 1'b0, k <= 8, k == 8, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_after k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_fault got=%b exp=0", fault);
    end
  endtask

  initial begin
    test_reset();
    test_set_sequence();
    test_skip();
    test_both_clear();
    test_pending();
    test_fault();
    test_reset_mid();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL overlap count got=%0d exp=0", overlap_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
